cfg_write_sequencer: RTL and testbench

- Queues Avalon-MM configuration write commands (address, byte-enable, data) from a control source.
- Dispatches them one at a time to the single-write FSM (cfg_write_fsm) directly downstream, using its start/done handshake.
- Holds address, data and byte-enable stable for the whole transaction; monitors completion with a timeout and reports status.

---
 rtl/cfg_seq_pkg.sv | 36 +++
 rtl/cfg_cmd_fifo.sv | 86 ++++++++
 rtl/cfg_write_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cfg_write_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// -----------------------------------------------------------------------------
// cfg_seq_pkg
// Shared types and default widths for the configuration write sequencer.
//   state_e      : dispatch FSM states (IDLE, ISSUE, WAIT_DONE)
//   cmd_t        : one queued write command {addr, be, data} at default widths
//   timer_width  : width needed to count up to a timeout value (min 1 bit)
// -----------------------------------------------------------------------------
package cfg_seq_pkg;

  localparam int CFG_DEPTH   = 8;
  localparam int CFG_TIMEOUT = 1024;
  localparam int CFG_ADDR_W  = 17;
  localparam int CFG_DATA_W  = 32;
  localparam int CFG_BE_W    = CFG_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_BE_W-1:0]   be;
    logic [CFG_DATA_W-1:0] data;
  } cmd_t;

  // A counter that must be able to hold the value 'cycles'.
  function automatic int timer_width(input int cycles);
    if (cycles < 2) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cfg_cmd_fifo
// Synchronous FIFO holding packed write commands.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push/wdata : write one entry (ignored when full or during flush)
//   pop/rdata  : rdata always shows the head; pop advances it (ignored when
//                empty or during flush)
//   flush      : empties the FIFO at the edge; wins over push and pop
//   full/empty/count : occupancy status, count in 0..DEPTH
// -----------------------------------------------------------------------------
module cfg_cmd_fifo
  import cfg_seq_pkg::*;
#(
  parameter int DEPTH = CFG_DEPTH,
  parameter int W     = $bits(cmd_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never read beyond 'count', so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/cfg_write_sequencer.sv
// -----------------------------------------------------------------------------
// cfg_write_sequencer
// Queues configuration write commands and dispatches them one at a time to the
// downstream single-write FSM through a start/done handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command push handshake (cmd_ready = not full)
//   cmd_addr/be/data      : command contents
//   flush                 : drop every queued (not in-flight) command
//   start_single_write    : one-cycle start pulse to the write FSM
//   write_addr/be/data_out: held command for the transaction in flight
//   single_write_done_in  : one-cycle completion pulse from the write FSM
//   busy                  : FSM not idle or FIFO non-empty
//   pending_count         : FIFO occupancy
//   done_count            : completed writes, wraps at 16 bits
//   err_timeout           : sticky, set when WAIT_DONE lasts TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module cfg_write_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int DEPTH          = CFG_DEPTH,
  parameter int TIMEOUT_CYCLES = CFG_TIMEOUT,
  parameter int ADDR_W         = CFG_ADDR_W,
  parameter int DATA_W         = CFG_DATA_W,
  parameter int BE_W           = CFG_BE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [BE_W-1:0]        cmd_be,
  input  logic [DATA_W-1:0]      cmd_data,
  input  logic                   flush,
  output logic                   start_single_write,
  output logic [ADDR_W-1:0]      write_addr_out,
  output logic [BE_W-1:0]        write_be_out,
  output logic [DATA_W-1:0]      write_data_out,
  input  logic                   single_write_done_in,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending_count,
  output logic [15:0]            done_count,
  output logic                   err_timeout
);

  localparam int CMD_W = ADDR_W + BE_W + DATA_W;
  localparam int TMR_W = timer_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMR_W-1:0]   timer_inc;
  logic [15:0]        done_cnt_q, done_cnt_d;
  logic               err_q, err_d;
  logic               ready_en_q, ready_en_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CMD_W-1:0]   fifo_rdata;
  logic [ADDR_W-1:0]  head_addr;
  logic [BE_W-1:0]    head_be;
  logic [DATA_W-1:0]  head_data;

  // cmd_ready stays low while in reset and for the release cycle itself,
  // so no command can slip in on the first edge after reset deasserts.
  assign ready_en_d = 1'b1;
  assign cmd_ready  = ready_en_q && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;

  assign {head_addr, head_be, head_data} = fifo_rdata;

  cfg_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({cmd_addr, cmd_be, cmd_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_count)
  );

  assign write_addr_out = addr_q;
  assign write_be_out   = be_q;
  assign write_data_out = data_q;
  assign done_count     = done_cnt_q;
  assign err_timeout    = err_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    be_d               = be_q;
    data_d             = data_q;
    timer_d            = timer_q;
    done_cnt_d         = done_cnt_q;
    err_d              = err_q;
    fifo_pop           = 1'b0;
    start_single_write = 1'b0;
    // Saturating increment: the counter parks at the timeout value.
    timer_inc          = (timer_q == TMO) ? TMO : timer_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        // A flush on the same edge empties the FIFO, so the pop is withheld.
        if (!fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          be_d     = head_be;
          data_d   = head_data;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_single_write = 1'b1;
        timer_d            = '0;
        state_d            = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (single_write_done_in) begin
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_inc;
          // Flag only; the downstream FSM cannot be aborted, so keep waiting.
          if ((TIMEOUT_CYCLES != 0) && (timer_inc == TMO)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      done_cnt_q <= done_cnt_d;
      err_q      <= err_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_cfg_write_sequencer.sv
module tb_cfg_write_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;
  localparam int AW    = 17;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int LAT   = 4;

  localparam int E_IDLE  = 0;
  localparam int E_ISSUE = 1;
  localparam int E_WAIT  = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
  } cmd_s;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [BW-1:0] cmd_be = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          flush = 1'b0;
  logic          start_single_write;
  logic [AW-1:0] write_addr_out;
  logic [BW-1:0] write_be_out;
  logic [DW-1:0] write_data_out;
  logic          resp_done = 1'b0;
  logic          stray_done = 1'b0;
  logic          done_in;
  logic          busy;
  logic [3:0]    pending_count;
  logic [15:0]   done_count;
  logic          err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit stall_done = 1'b0;

  assign done_in = resp_done | stray_done;

  cfg_write_sequencer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .BE_W           (BW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_addr             (cmd_addr),
    .cmd_be               (cmd_be),
    .cmd_data             (cmd_data),
    .flush                (flush),
    .start_single_write   (start_single_write),
    .write_addr_out       (write_addr_out),
    .write_be_out         (write_be_out),
    .write_data_out       (write_data_out),
    .single_write_done_in (done_in),
    .busy                 (busy),
    .pending_count        (pending_count),
    .done_count           (done_count),
    .err_timeout          (err_timeout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream write FSM stand-in: done LAT cycles after start, or later
  // while stall_done is held. Abandons the transaction on reset.
  initial begin
    int k;
    forever begin
      @(posedge clk);
      #1;
      if (start_single_write === 1'b1) begin
        k = 0;
        while ((k < LAT || stall_done) && k < 5000 && rst_n) begin
          @(posedge clk);
          #1;
          k++;
        end
        if (rst_n) begin
          resp_done = 1'b1;
          @(posedge clk);
          #1;
          resp_done = 1'b0;
        end
      end
    end
  end

  // Reference model: a command queue, an abstract engine phase and the
  // observable counters, advanced once per cycle from the input values that
  // the coming rising edge will sample.
  cmd_s        m_q[$];
  cmd_s        m_hold = '0;
  int          m_eng  = E_IDLE;
  int          m_wait = 0;
  logic [15:0] m_done = '0;
  bit          m_err  = 1'b0;
  bit          m_rdy  = 1'b0;
  int          start_cyc[$];

  always @(negedge clk) begin
    bit   acc;
    cmd_s c;
    if (!rst_n) begin
      chk("rst_ready",   cmd_ready, 0);
      chk("rst_start",   start_single_write, 0);
      chk("rst_busy",    busy, 0);
      chk("rst_pending", pending_count, 0);
      chk("rst_done",    done_count, 0);
      chk("rst_err",     err_timeout, 0);
      chk("rst_hold",    {write_addr_out, write_be_out, write_data_out}, 0);
      m_q.delete();
      m_hold = '0;
      m_eng  = E_IDLE;
      m_wait = 0;
      m_done = '0;
      m_err  = 1'b0;
      m_rdy  = 1'b0;
    end else begin
      chk("ready",   cmd_ready, (m_rdy && m_q.size() < DEPTH));
      chk("pending", pending_count, m_q.size());
      chk("busy",    busy, (m_eng != E_IDLE || m_q.size() > 0));
      chk("start",   start_single_write, (m_eng == E_ISSUE));
      chk("addr",    write_addr_out, m_hold.a);
      chk("be",      write_be_out, m_hold.be);
      chk("data",    write_data_out, m_hold.d);
      chk("done_cnt", done_count, m_done);
      chk("err",     err_timeout, m_err);
      if (start_single_write === 1'b1) start_cyc.push_back(cyc);

      acc = cmd_valid && m_rdy && (m_q.size() < DEPTH);
      c   = '{a: cmd_addr, be: cmd_be, d: cmd_data};
      case (m_eng)
        E_IDLE: begin
          if (m_q.size() > 0 && !flush) begin
            m_hold = m_q.pop_front();
            m_eng  = E_ISSUE;
          end
        end
        E_ISSUE: begin
          m_eng  = E_WAIT;
          m_wait = 0;
        end
        default: begin
          if (done_in) begin
            m_done = m_done + 16'd1;
            m_eng  = E_IDLE;
          end else begin
            if (m_wait < TMO) m_wait++;
            if (m_wait >= TMO) m_err = 1'b1;
          end
        end
      endcase
      if (flush) m_q.delete();
      else if (acc) m_q.push_back(c);
      m_rdy = 1'b1;
    end
  end

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy !== 1'b0 && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic set_rand_cmd();
    cmd_addr = AW'($urandom);
    cmd_be   = BW'($urandom);
    cmd_data = $urandom;
  endtask

  initial begin
    // Reset and release
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_d", cmd_ready, 0);
    chk("rst_busy_d", busy, 0);
    rst_n = 1'b1;
    chk("rel_ready0", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_ready1", cmd_ready, 1);

    // Single write with start two cycles after the push edge
    cmd_valid = 1'b1;
    cmd_addr  = 17'h00104;
    cmd_be    = 4'hF;
    cmd_data  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("single_lat1", start_single_write, 0);
    @(posedge clk);
    #1;
    chk("single_start", start_single_write, 1);
    chk("single_addr", write_addr_out, 17'h00104);
    chk("single_be", write_be_out, 4'hF);
    chk("single_data", write_data_out, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    chk("single_pulse", start_single_write, 0);
    wait_idle(50);
    chk("single_done", done_count, 1);

    // Stray done while idle is ignored
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    @(posedge clk);
    #1;
    chk("stray_done", done_count, 1);

    // Flush coinciding with the pop in IDLE suppresses the pop
    cmd_valid = 1'b1;
    set_rand_cmd();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flpop_pending", pending_count, 0);
    chk("flpop_start", start_single_write, 0);
    chk("flpop_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("flpop_start2", start_single_write, 0);

    // Burst of 8: one write every LAT+2 cycles
    start_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1;
      set_rand_cmd();
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    wait_idle(200);
    chk("burst_starts", start_cyc.size(), 8);
    for (int i = 1; i < start_cyc.size(); i++) begin
      chk("burst_gap", start_cyc[i] - start_cyc[i-1], LAT + 2);
    end
    chk("burst_done", done_count, 9);

    // Overflow: 10 pushes with done stalled, one popped, FIFO caps at 8
    stall_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      set_rand_cmd();
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("ovf_pending", pending_count, 8);
    chk("ovf_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("ovf_pending2", pending_count, 8);
    stall_done = 1'b0;
    wait_idle(300);
    chk("ovf_done", done_count, 18);

    // Flush with simultaneous push: 5 queued, 1 in flight
    stall_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      set_rand_cmd();
      @(posedge clk);
      #1;
    end
    chk("fl_pending_pre", pending_count, 5);
    flush = 1'b1;
    set_rand_cmd();
    @(posedge clk);
    #1;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    chk("fl_pending", pending_count, 0);
    chk("fl_busy", busy, 1);
    stall_done = 1'b0;
    wait_idle(100);
    chk("fl_done", done_count, 19);

    // Timeout after 16 WAIT_DONE cycles; late done still completes
    stall_done = 1'b1;
    cmd_valid  = 1'b1;
    set_rand_cmd();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("tmo_start", start_single_write, 1);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    chk("tmo_err_before", err_timeout, 0);
    @(posedge clk);
    #1;
    chk("tmo_err_set", err_timeout, 1);
    stall_done = 1'b0;
    wait_idle(100);
    chk("tmo_done", done_count, 20);
    chk("tmo_err_sticky", err_timeout, 1);

    // Asynchronous reset in the middle of WAIT_DONE
    stall_done = 1'b1;
    cmd_valid  = 1'b1;
    set_rand_cmd();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_start", start_single_write, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 0);
    chk("arst_pending", pending_count, 0);
    chk("arst_done", done_count, 0);
    chk("arst_err", err_timeout, 0);
    chk("arst_hold", {write_addr_out, write_be_out, write_data_out}, 0);
    stall_done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arel_ready0", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("arel_ready1", cmd_ready, 1);
    chk("arel_start", start_single_write, 0);

    // Normal operation after reset
    cmd_valid = 1'b1;
    set_rand_cmd();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle(50);
    chk("post_done", done_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
